mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Pipeline-side initiator for data-memory accesses in the MEM stage. Takes a load/store from the pipeline (opcode, address, store data), checks alignment, drives byte-lane strobes and replicated store data onto a single-outstanding req/ack data bus, stalls the pipeline until the bus acknowledges, then returns sign- or zero-extended load data. Sits between the MEM-stage pipeline register and the data RAM controller.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus cycles to wait for `bus_ack` before aborting. Used only with `LSU_TIMEOUT_EN`. Range 1..65535.
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: MEM stage holds an instruction; `op`, `addr`, `wdata` stable while `stall`=1.
- `op` in 6: MIPS primary opcode (`LB`,`LH`,`LW`,`LBU`,`LHU`,`SB`,`SH`,`SW` from defines.vh).
- `addr` in 32: effective byte address.
- `wdata` in 32: store source register.
- `stall` out 1: hold pipeline (combinational).
- `done` out 1: one-cycle pulse, access complete; `rdata`/flags valid.
- `rdata` out 32: extended load result (0 for stores/faults).
- `adel` out 1: load address error; `ades` out 1: store address error.
- `bus_err` out 1: timeout abort (tied 0 without `LSU_TIMEOUT_EN`).
- `bus_req` out 1, `bus_wr` out 1, `bus_addr` out 32 (word-aligned, `{addr[31:2],2'b00}`), `bus_wstrb` out 4, `bus_wdata` out 32.
- `bus_ack` in 1: single-cycle acknowledge; `bus_rdata` in 32 valid in the ack cycle.

## Operation
- Little-endian lanes throughout: byte at `addr[1:0]`=k is lane k (`[8k+7:8k]`); halfword at offset 0 is `[15:0]`, offset 2 is `[31:16]`.
- Memory op = `req_valid` & `op` in the eight listed opcodes; any other `op` is ignored (no stall, no done).
- Alignment: LH/LHU/SH need `addr[0]`=0; LW/SW need `addr[1:0]`=0; bytes always aligned.
- Stores: SB `bus_wdata`={4{wdata[7:0]}}, `bus_wstrb`=4'b0001<<addr[1:0]; SH {2{wdata[15:0]}}, 4'b0011 or 4'b1100; SW wdata, 4'b1111. Loads: `bus_wstrb`=0, `bus_wr`=0.
- Load extraction from `bus_rdata` captured on ack: LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
- FSM states IDLE, REQ, DONE:
  - IDLE: memory op & aligned -> REQ (latch bus fields). Memory op & misaligned -> DONE with `adel` (loads) or `ades` (stores), no bus traffic.
  - REQ: `bus_req`=1, fields held constant; `bus_ack`=1 -> DONE, latch `rdata`.
  - DONE: `done`=1, `stall`=0 -> IDLE unconditionally.
- `stall` = (IDLE & memory op) | REQ.
- `bus_ack` outside REQ is ignored.

## Timing
- Reset (any time, including mid-REQ): state IDLE; `stall`,`done`,`bus_req`,`bus_wr`,`adel`,`ades`,`bus_err`=0; `rdata`,`bus_addr`,`bus_wdata`=0; `bus_wstrb`=0. `bus_req` drops asynchronously.
- Accept at edge 0; `bus_req` high cycle 1; ack in cycle 1 -> `done` cycle 2. Minimum 2 stall cycles; each extra ack-wait cycle adds one.
- Misaligned: 1 stall cycle, `done` next cycle.
- `rdata`,`adel`,`ades`,`bus_err` valid only while `done`=1; cleared to 0 on leaving DONE.
- Back-to-back: a new request is accepted in the IDLE cycle following DONE.

## Configuration
- `LSU_TIMEOUT_EN` defined: 16-bit counter cleared on REQ entry, increments each REQ cycle without ack; at `TIMEOUT_CYCLES` drop `bus_req`, enter DONE with `bus_err`=1, `rdata`=0. Ack in the same cycle as expiry wins (normal completion).
- Undefined: no counter; REQ waits indefinitely; `bus_err` constant 0.

## Test plan
- Hold `resetn`=0 during REQ with `bus_req`=1 -> `bus_req`=0 immediately, all outputs 0, IDLE after release.
- LB addr 0x1003, ack cycle 1 with `bus_rdata`=0x80FF1234 -> `bus_addr`=0x1000, `wstrb`=0, `done` cycle 2, `rdata`=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x2002, `wdata`=0x1234ABCD -> `bus_wr`=1, `wstrb`=4'b1100, `bus_wdata`=0xABCDABCD, `rdata`=0 at done.
- LW addr 0x0006 -> `adel`=1 with `done` next cycle, `bus_req` never asserts; SW addr 0x0001 -> `ades`=1.
- LHU addr 0x0002, ack delayed 5 cycles -> `stall` high 6 cycles, bus fields constant, `rdata`=`bus_rdata[31:16]` zero-extended.
- With `LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack -> `bus_req` drops after 4 REQ cycles, `done`&`bus_err`=1; late ack afterwards ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator on a single-outstanding
// req/ack data bus. Checks alignment, builds byte strobes and replicated
// store data, stalls the pipeline until ack, and returns extended load data.
// Optional feature macro: LSU_TIMEOUT_EN (abort a bus request after
// TIMEOUT_CYCLES REQ cycles without ack and report bus_err).
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        adel,
  output logic        ades,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // MIPS primary opcodes for the supported loads and stores
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      r_state;
  logic        r_done;
  logic [31:0] r_rdata;
  logic        r_adel;
  logic        r_ades;
  logic        r_bus_req;
  logic        r_bus_wr;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_wstrb;
  logic [31:0] r_bus_wdata;
  logic [5:0]  r_op;
  logic [1:0]  r_off;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_aligned;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic        w_mem_op;

  // Select the addressed byte/halfword lane and extend it per load type
  function automatic logic [31:0] f_load_ext(input logic [5:0] i_op,
                                             input logic [1:0] i_off,
                                             input logic [31:0] i_d);
    logic [7:0]  v_b;
    logic [15:0] v_h;
    logic [31:0] v_r;
    case (i_off)
      2'd0:    v_b = i_d[7:0];
      2'd1:    v_b = i_d[15:8];
      2'd2:    v_b = i_d[23:16];
      default: v_b = i_d[31:24];
    endcase
    v_h = i_off[1] ? i_d[31:16] : i_d[15:0];
    case (i_op)
      OP_LB:   v_r = {{24{v_b[7]}}, v_b};
      OP_LBU:  v_r = {24'd0, v_b};
      OP_LH:   v_r = {{16{v_h[15]}}, v_h};
      OP_LHU:  v_r = {16'd0, v_h};
      OP_LW:   v_r = i_d;
      default: v_r = 32'd0;
    endcase
    return v_r;
  endfunction

  // Decode opcode class, alignment, strobes and replicated store data
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_aligned  = 1'b1;
    w_wstrb    = 4'b0000;
    w_wdata    = 32'd0;
    case (op)
      OP_LB, OP_LBU: w_is_load = 1'b1;
      OP_LH, OP_LHU: begin
        w_is_load = 1'b1;
        w_aligned = ~addr[0];
      end
      OP_LW: begin
        w_is_load = 1'b1;
        w_aligned = (addr[1:0] == 2'b00);
      end
      OP_SB: begin
        w_is_store = 1'b1;
        w_wstrb    = 4'b0001 << addr[1:0];
        w_wdata    = {4{wdata[7:0]}};
      end
      OP_SH: begin
        w_is_store = 1'b1;
        w_aligned  = ~addr[0];
        w_wstrb    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{wdata[15:0]}};
      end
      OP_SW: begin
        w_is_store = 1'b1;
        w_aligned  = (addr[1:0] == 2'b00);
        w_wstrb    = 4'b1111;
        w_wdata    = wdata;
      end
      default: ;
    endcase
  end

  assign w_mem_op = req_valid & (w_is_load | w_is_store);

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] LP_TO_M1 = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_cnt;
  logic        r_bus_err;
  assign bus_err = r_bus_err;
`else
  logic w_unused_param;
  assign w_unused_param = ^(16'(TIMEOUT_CYCLES));
  assign bus_err = 1'b0;
`endif

  // Control FSM with registered bus fields and result flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_done      <= 1'b0;
      r_rdata     <= 32'd0;
      r_adel      <= 1'b0;
      r_ades      <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_wstrb <= 4'b0000;
      r_bus_wdata <= 32'd0;
      r_op        <= 6'd0;
      r_off       <= 2'd0;
`ifdef LSU_TIMEOUT_EN
      r_cnt       <= 16'd0;
      r_bus_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            if (w_aligned) begin
              r_state     <= S_REQ;
              r_bus_req   <= 1'b1;
              r_bus_wr    <= w_is_store;
              r_bus_addr  <= {addr[31:2], 2'b00};
              r_bus_wstrb <= w_wstrb;
              r_bus_wdata <= w_wdata;
              r_op        <= op;
              r_off       <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
              r_cnt       <= 16'd0;
`endif
            end else begin
              // Misaligned: report the fault without touching the bus
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_adel  <= w_is_load;
              r_ades  <= w_is_store;
            end
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_rdata     <= r_bus_wr ? 32'd0 : f_load_ext(r_op, r_off, bus_rdata);
            r_bus_req   <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wstrb <= 4'b0000;
            r_bus_wdata <= 32'd0;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_cnt == LP_TO_M1) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_bus_err   <= 1'b1;
            r_rdata     <= 32'd0;
            r_bus_req   <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wstrb <= 4'b0000;
            r_bus_wdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
`endif
        end
        default: begin
          // Result is visible for exactly one cycle, then cleared
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_rdata <= 32'd0;
          r_adel  <= 1'b0;
          r_ades  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
          r_bus_err <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign stall     = ((r_state == S_IDLE) & w_mem_op) | (r_state == S_REQ);
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign adel      = r_adel;
  assign ades      = r_ades;
  assign bus_req   = r_bus_req;
  assign bus_wr    = r_bus_wr;
  assign bus_addr  = r_bus_addr;
  assign bus_wstrb = r_bus_wstrb;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

`ifdef LSU_TIMEOUT_EN
  localparam int LHU_WAIT = 3;
`else
  localparam int LHU_WAIT = 5;
`endif

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        adel;
  logic        ades;
  logic        bus_err;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_total = 0;
  int n_bad   = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .op(op),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .adel(adel), .ades(ades), .bus_err(bus_err), .bus_req(bus_req),
    .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one access starting just after a rising edge; ack_at = REQ cycle
  // in which ack is given (0 = expect no bus request at all).
  task automatic run_op(input string tag, input logic [5:0] o, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] brd,
                        input logic [31:0] exp_rd, input logic exp_wr,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                        input logic exp_adel, input logic exp_ades);
    int stalls;
    int reqc;
    stalls = 0;
    reqc   = 0;
    req_valid = 1'b1; op = o; addr = a; wdata = wd;
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      if (done) break;
      if (stall) stalls++;
      if (bus_req) begin
        reqc++;
        if (reqc == 1 || reqc == ack_at) begin
          chk({tag, " bus_addr"}, bus_addr, {a[31:2], 2'b00});
          chk({tag, " bus_wr"}, bus_wr, exp_wr);
          chk({tag, " bus_wstrb"}, bus_wstrb, exp_strb);
          if (exp_wr) chk({tag, " bus_wdata"}, bus_wdata, exp_wd);
        end
        if (reqc == ack_at) begin
          bus_ack = 1'b1;
          bus_rdata = brd;
        end
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      bus_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " rdata"}, rdata, exp_rd);
    chk({tag, " adel"}, adel, exp_adel);
    chk({tag, " ades"}, ades, exp_ades);
    chk({tag, " bus_err"}, bus_err, 1'b0);
    chk({tag, " stall_cycles"}, stalls, ack_at + 1);
    chk({tag, " req_cycles"}, reqc, ack_at);
    chk({tag, " stall_in_done"}, stall, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0; op = 6'd0;
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 1'b0);
    chk({tag, " rdata_clr"}, rdata, 32'd0);
    chk({tag, " flags_clr"}, {adel, ades}, 2'b00);
    @(posedge clk); #1;
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; op = 6'd0; addr = 32'd0; wdata = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst stall", stall, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst bus_req", bus_req, 1'b0);
    chk("rst bus_fields", {bus_wr, bus_wstrb}, 5'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst flags", {adel, ades, bus_err}, 3'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op("LB",  OP_LB,  32'h0000_1003, 32'h0, 1, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    run_op("LBU", OP_LBU, 32'h0000_1003, 32'h0, 1, 32'h80FF_1234, 32'h0000_0080, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    run_op("LB1", OP_LB,  32'h0000_0001, 32'h0, 1, 32'h0000_7F00, 32'h0000_007F, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    run_op("SH",  OP_SH,  32'h0000_2002, 32'h1234_ABCD, 1, 32'h5555_5555, 32'h0, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0, 1'b0);
    run_op("SB",  OP_SB,  32'h0000_0003, 32'h0000_00A5, 2, 32'h0, 32'h0, 1'b1, 4'b1000, 32'hA5A5_A5A5, 1'b0, 1'b0);
    run_op("SW",  OP_SW,  32'h0000_0010, 32'hCAFE_F00D, 1, 32'h0, 32'h0, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0);
    run_op("LH",  OP_LH,  32'h0000_0000, 32'h0, 1, 32'h1234_8001, 32'hFFFF_8001, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    run_op("LW",  OP_LW,  32'h0000_0024, 32'h0, 1, 32'h89AB_CDEF, 32'h89AB_CDEF, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    run_op("LHU", OP_LHU, 32'h0000_0002, 32'h0, LHU_WAIT, 32'h8001_7FFE, 32'h0000_8001, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    run_op("LWmis", OP_LW, 32'h0000_0006, 32'h0, 0, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    run_op("SWmis", OP_SW, 32'h0000_0001, 32'h0, 0, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1);
    run_op("LHmis", OP_LH, 32'h0000_0003, 32'h0, 0, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    run_op("SHmis", OP_SH, 32'h0000_0001, 32'h0, 0, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1);

    // Non-memory opcode is ignored, and ack outside REQ does nothing
    req_valid = 1'b1; op = 6'h00; addr = 32'h100;
    bus_ack = 1'b1;
    @(negedge clk);
    chk("nop stall", stall, 1'b0);
    @(negedge clk);
    chk("nop done", done, 1'b0);
    chk("nop bus_req", bus_req, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0; bus_ack = 1'b0;
    @(posedge clk); #1;

    // Reset asserted mid-REQ
    req_valid = 1'b1; op = OP_LW; addr = 32'h0000_0100;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid pre bus_req", bus_req, 1'b1);
    #2;
    req_valid = 1'b0; op = 6'd0;
    resetn = 1'b0;
    #1;
    chk("rstmid bus_req", bus_req, 1'b0);
    chk("rstmid stall", stall, 1'b0);
    chk("rstmid bus_addr", bus_addr, 32'd0);
    chk("rstmid done", done, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rstmid idle bus_req", bus_req, 1'b0);
    chk("rstmid idle done", done, 1'b0);
    @(posedge clk); #1;
    run_op("postrst LW", OP_LW, 32'h0000_0100, 32'h0, 1, 32'h0123_4567, 32'h0123_4567, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);

`ifdef LSU_TIMEOUT_EN
    begin
      int reqc;
      reqc = 0;
      req_valid = 1'b1; op = OP_LW; addr = 32'h0000_0040;
      @(negedge clk);
      for (int c = 0; c < 20; c++) begin
        if (done) break;
        if (bus_req) reqc++;
        @(negedge clk);
      end
      chk("to done", done, 1'b1);
      chk("to bus_err", bus_err, 1'b1);
      chk("to rdata", rdata, 32'd0);
      chk("to req_cycles", reqc, 4);
      chk("to bus_req", bus_req, 1'b0);
      @(posedge clk); #1;
      req_valid = 1'b0; op = 6'd0;
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("to late done", done, 1'b0);
      chk("to late err_clr", bus_err, 1'b0);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      chk("to late done2", done, 1'b0);
      @(posedge clk); #1;
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
